// File: rtl/serial_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : serial_pkg
//  Description : Shared types, constants and the round-robin pick helper for
//                the serial transmit arbiter and its bit shifter.
//                Optional feature macro: TX_PARITY_EN (adds an odd parity bit).
//  Revision    : 1.0 - initial release
// ============================================================================
package serial_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;
    localparam int   DATA_BITS = 8;

    // Widest request vector rr_pick accepts; callers zero-extend into it.
    localparam int   MAX_REQ   = 32;

    // First index i with req[i]=1, scanning upward from ptr and wrapping at n.
    // Returns ptr when nothing is requesting; callers qualify with |req.
    function automatic int unsigned rr_pick(input logic [MAX_REQ-1:0] req,
                                            input int unsigned        ptr,
                                            input int unsigned        n);
        int unsigned idx;
        logic        found;
        rr_pick = ptr;
        found   = 1'b0;
        for (int unsigned k = 0; k < MAX_REQ; k++) begin
            if (k < n) begin
                idx = (ptr + k) % n;
                if (!found && req[idx[4:0]]) begin
                    rr_pick = idx;
                    found   = 1'b1;
                end
            end
        end
    endfunction

endpackage
`default_nettype wire

// File: rtl/serial_tx_shifter.sv
`default_nettype none
// ============================================================================
//  Module      : serial_tx_shifter
//  Description : Bit-level datapath of the serial transmitter. Holds the byte
//                shift register, the 3-bit data-bit counter, the per-bit cycle
//                counter and the registered tx line. Driven by the arbiter FSM
//                through a load strobe plus its current and next state.
//                With TX_PARITY_EN defined it also latches the odd parity bit.
//  Ports       : clk, rst       - clock, synchronous active-high reset
//                i_load         - capture i_byte at this edge (new frame)
//                i_byte         - byte to be framed
//                i_state        - FSM state for the current cycle
//                i_state_nxt    - FSM state for the next cycle (selects tx)
//                o_bit_end      - last cycle of the current serial bit
//                o_last_bit     - data bit 7 is on the line
//                o_tx           - registered serial output
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_tx_shifter
    import serial_pkg::*;
#(
    parameter int BIT_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_load,
    input  logic [7:0] i_byte,
    input  tx_state_t  i_state,
    input  tx_state_t  i_state_nxt,
    output logic       o_bit_end,
    output logic       o_last_bit,
    output logic       o_tx
);

    localparam int c_CYC_W = $clog2(BIT_CYCLES + 1);

    logic [c_CYC_W-1:0] r_cyc;
    logic [2:0]         r_bit;
    logic [7:0]         r_sh;
    logic [7:0]         w_sh_nxt;
    logic               w_shift;
`ifdef TX_PARITY_EN
    logic               r_par;
`endif

    assign o_bit_end  = (r_cyc == c_CYC_W'(BIT_CYCLES - 1));
    assign o_last_bit = (r_bit == 3'(DATA_BITS - 1));
    assign w_shift    = (i_state == DATA) && o_bit_end;

    // Next shift-register contents; tx for a DATA cycle is taken from its LSB
    // so the line and the register advance on the same edge.
    always_comb begin
        w_sh_nxt = r_sh;
        if (i_load) begin
            w_sh_nxt = i_byte;
        end else if (w_shift) begin
            w_sh_nxt = {1'b0, r_sh[7:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cyc <= '0;
            r_bit <= '0;
            r_sh  <= '0;
            o_tx  <= STOP_BIT;
`ifdef TX_PARITY_EN
            r_par <= 1'b0;
`endif
        end else begin
            // Counter restarts at every bit boundary so it never wraps mid-bit.
            if ((i_state == IDLE) || o_bit_end) begin
                r_cyc <= '0;
            end else begin
                r_cyc <= r_cyc + c_CYC_W'(1);
            end

            if (i_load) begin
                r_bit <= '0;
            end else if (w_shift) begin
                r_bit <= r_bit + 3'd1;
            end

            r_sh <= w_sh_nxt;

`ifdef TX_PARITY_EN
            if (i_load) begin
                r_par <= ~^i_byte;
            end
`endif

            case (i_state_nxt)
                START:   o_tx <= START_BIT;
                DATA:    o_tx <= w_sh_nxt[0];
`ifdef TX_PARITY_EN
                PARITY:  o_tx <= r_par;
`endif
                default: o_tx <= STOP_BIT;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/serial_tx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : serial_tx_arbiter
//  Description : Round-robin arbiter sharing one serial tx line among N_REQ
//                byte requesters. Each granted byte is sent as start bit,
//                8 data bits LSB first, optional odd parity bit, stop bit.
//                Optional feature macro: TX_PARITY_EN (11-bit frames).
//  Ports       : clk    - clock
//                reset  - synchronous active-high reset
//                req    - [N_REQ] byte pending per requester
//                data   - [8*N_REQ] requester i byte on data[8i+7:8i]
//                grant  - [N_REQ] one-cycle one-hot capture pulse
//                owner  - index of the current/last frame owner
//                busy   - high for every cycle of a frame
//                tx     - registered serial line, idles high
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_tx_arbiter
    import serial_pkg::*;
#(
    parameter int N_REQ      = 4,
    parameter int BIT_CYCLES = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [N_REQ-1:0]         req,
    input  logic [8*N_REQ-1:0]       data,
    output logic [N_REQ-1:0]         grant,
    output logic [$clog2(N_REQ)-1:0] owner,
    output logic                     busy,
    output logic                     tx
);

    localparam int c_OWNER_W = $clog2(N_REQ);

    tx_state_t              r_state;
    tx_state_t              w_state_nxt;
    logic [c_OWNER_W-1:0]   r_ptr;
    logic [c_OWNER_W-1:0]   w_winner;
    logic [MAX_REQ-1:0]     w_req_ext;
    logic [7:0]             w_byte;
    logic                   w_any_req;
    logic                   w_load;
    logic                   w_bit_end;
    logic                   w_last_bit;

    assign w_any_req = |req;
    assign w_req_ext = MAX_REQ'(req);
    assign w_winner  = c_OWNER_W'(rr_pick(w_req_ext, 32'(r_ptr), 32'(N_REQ)));

    // Capture happens from IDLE, or on the final stop-bit cycle so that a
    // waiting requester starts its frame with no idle bit in between.
    assign w_load = w_any_req &&
                    ((r_state == IDLE) || ((r_state == STOP) && w_bit_end));

    always_comb begin
        w_byte = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_winner == c_OWNER_W'(i)) begin
                w_byte = data[8*i +: 8];
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_any_req) w_state_nxt = START;
            end
            START: begin
                if (w_bit_end) w_state_nxt = DATA;
            end
            DATA: begin
                if (w_bit_end && w_last_bit) begin
`ifdef TX_PARITY_EN
                    w_state_nxt = PARITY;
`else
                    w_state_nxt = STOP;
`endif
                end
            end
`ifdef TX_PARITY_EN
            PARITY: begin
                if (w_bit_end) w_state_nxt = STOP;
            end
`endif
            STOP: begin
                if (w_bit_end) w_state_nxt = w_any_req ? START : IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_ptr   <= '0;
            grant   <= '0;
            owner   <= '0;
            busy    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            grant   <= '0;
            if (w_load) begin
                grant <= N_REQ'(1) << w_winner;
                owner <= w_winner;
                busy  <= 1'b1;
                // Next scan starts just past the winner.
                r_ptr <= (w_winner == c_OWNER_W'(N_REQ - 1)) ?
                         '0 : (w_winner + c_OWNER_W'(1));
            end else if (w_state_nxt == IDLE) begin
                busy  <= 1'b0;
            end
        end
    end

    serial_tx_shifter #(
        .BIT_CYCLES (BIT_CYCLES)
    ) u_shifter (
        .clk         (clk),
        .rst         (reset),
        .i_load      (w_load),
        .i_byte      (w_byte),
        .i_state     (r_state),
        .i_state_nxt (w_state_nxt),
        .o_bit_end   (w_bit_end),
        .o_last_bit  (w_last_bit),
        .o_tx        (tx)
    );

endmodule
`default_nettype wire

// File: tb/tb_serial_tx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_tx_arbiter
//  Description : Directed bench for serial_tx_arbiter. A 4-requester,
//                1-cycle-per-bit instance runs a vector table plus the
//                back-to-back, withdrawn-request and reset sequences; a
//                3-cycle-per-bit instance checks bit stretching.
//                Honours TX_PARITY_EN (11-bit frames with odd parity).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_tx_arbiter;

`ifdef TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    typedef struct {
        logic [3:0]  req;
        logic [31:0] data;
        logic [3:0]  exp_grant;
        logic [1:0]  exp_owner;
        logic [9:0]  frame;     // frame[k] = k-th bit on the line (no parity)
        logic        exp_par;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req,   req3;
    logic [31:0] data,  data3;
    logic [3:0]  grant, grant3;
    logic [1:0]  owner, owner3;
    logic        busy,  busy3;
    logic        tx,    tx3;

    int n_cmp = 0;
    int n_err = 0;

    vec_t vecs[8];

    always #5 clk = ~clk;

    serial_tx_arbiter #(.N_REQ(4), .BIT_CYCLES(1)) u_dut (
        .clk(clk), .reset(reset), .req(req), .data(data),
        .grant(grant), .owner(owner), .busy(busy), .tx(tx)
    );

    serial_tx_arbiter #(.N_REQ(4), .BIT_CYCLES(3)) u_dut3 (
        .clk(clk), .reset(reset), .req(req3), .data(data3),
        .grant(grant3), .owner(owner3), .busy(busy3), .tx(tx3)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Expected line value k cycles-of-bits into a frame.
    function automatic logic exp_bit(input logic [9:0] frame, input logic par, input int k);
`ifdef TX_PARITY_EN
        if (k < 9)       return frame[4'(k)];
        else if (k == 9) return par;
        else             return frame[9];
`else
        if (k > 9) return par;
        return frame[4'(k)];
`endif
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic ok;

        //            req      data           grant    own    frame            par
        vecs[0] = '{4'b0001, 32'h000000A5, 4'b0001, 2'd0, 10'b11_0100_1010, 1'b1};
        vecs[1] = '{4'b1001, 32'h3C0000FF, 4'b1000, 2'd3, 10'b10_0111_1000, 1'b1};
        vecs[2] = '{4'b0110, 32'h00800100, 4'b0010, 2'd1, 10'b10_0000_0010, 1'b0};
        vecs[3] = '{4'b0110, 32'h00800100, 4'b0100, 2'd2, 10'b11_0000_0000, 1'b0};
        vecs[4] = '{4'b0011, 32'h0000FF00, 4'b0001, 2'd0, 10'b10_0000_0000, 1'b1};
        vecs[5] = '{4'b0011, 32'h0000FF00, 4'b0010, 2'd1, 10'b11_1111_1110, 1'b1};
        vecs[6] = '{4'b0100, 32'h00030000, 4'b0100, 2'd2, 10'b10_0000_0110, 1'b1};
        vecs[7] = '{4'b1000, 32'h07000000, 4'b1000, 2'd3, 10'b10_0000_1110, 1'b0};

        reset = 1'b1; req = '0; data = '0; req3 = '0; data3 = '0;
        tick();
        check("reset tx",    32'(tx),    32'd1);
        check("reset grant", 32'(grant), 32'd0);
        check("reset busy",  32'(busy),  32'd0);
        check("reset owner", 32'(owner), 32'd0);
        check("reset tx3",   32'(tx3),   32'd1);
        tick(); tick();
        reset = 1'b0;
        tick();

        // Bit stretching: 0x01 at 3 cycles per bit.
        req3 = 4'b0001; data3 = 32'h00000001;
        tick();
        check("bc3 grant", 32'(grant3), 32'b0001);
        req3 = '0;
        for (int k = 0; k < NB*3; k++) begin
            check($sformatf("bc3 tx cycle %0d", k), 32'(tx3), 32'(exp_bit(10'b10_0000_0010, 1'b0, k/3)));
            if (k == NB*3-1) check("bc3 busy last", 32'(busy3), 32'd1);
            tick();
        end
        check("bc3 busy end", 32'(busy3), 32'd0);
        check("bc3 tx idle",  32'(tx3),   32'd1);

        // Single frames from idle, pointer carried across vectors.
        for (int i = 0; i < 8; i++) begin
            req = vecs[i].req; data = vecs[i].data;
            tick();
            check($sformatf("v%0d grant", i), 32'(grant), 32'(vecs[i].exp_grant));
            check($sformatf("v%0d owner", i), 32'(owner), 32'(vecs[i].exp_owner));
            check($sformatf("v%0d busy", i),  32'(busy),  32'd1);
            req = '0;
            for (int k = 0; k < NB; k++) begin
                check($sformatf("v%0d tx bit %0d", i, k), 32'(tx),
                      32'(exp_bit(vecs[i].frame, vecs[i].exp_par, k)));
                if (k == NB-1) check($sformatf("v%0d busy last", i), 32'(busy), 32'd1);
                tick();
            end
            check($sformatf("v%0d busy end", i), 32'(busy), 32'd0);
            check($sformatf("v%0d tx idle", i),  32'(tx),   32'd1);
        end

        // Back-to-back: all requesting, grants 0,1,2,3,0 exactly NB apart.
        req = 4'b1111; data = 32'h55555555;
        tick();
        for (int f = 0; f < 5; f++) begin
            check($sformatf("b2b grant %0d", f), 32'(grant), 32'(4'b0001 << (f % 4)));
            check($sformatf("b2b owner %0d", f), 32'(owner), 32'(f % 4));
            check($sformatf("b2b tx start %0d", f), 32'(tx), 32'd0);
            if (f == 4) req = '0;
            ok = 1'b1;
            for (int c = 1; c <= NB; c++) begin
                tick();
                if (c < NB && (grant !== 4'b0000 || busy !== 1'b1)) ok = 1'b0;
            end
            check($sformatf("b2b quiet frame %0d", f), 32'(ok), 32'd1);
        end
        check("b2b busy end", 32'(busy), 32'd0);

        // Withdrawn request: req[2] pulses mid-frame of owner 1, never granted.
        req = 4'b0010; data = 32'h00005A00;
        tick();
        check("wd grant1", 32'(grant), 32'b0010);
        check("wd owner1", 32'(owner), 32'd1);
        req = '0;
        ok = 1'b1;
        for (int c = 1; c <= NB; c++) begin
            tick();
            if (c == 3) req = 4'b0100;
            if (c == 5) req = 4'b0000;
            if (c == 7) req = 4'b1001;
            if (c < NB && grant !== 4'b0000) ok = 1'b0;
        end
        check("wd no stray grant", 32'(ok),    32'd1);
        check("wd next grant",     32'(grant), 32'b1000);
        check("wd next owner",     32'(owner), 32'd3);
        check("wd next tx",        32'(tx),    32'd0);
        req = '0;
        for (int c = 0; c < NB; c++) tick();
        check("wd busy end", 32'(busy), 32'd0);

        // Reset mid-frame aborts it and restores requester 0 priority.
        req = 4'b0100; data = 32'h00A50000;
        tick();
        check("rst pre grant", 32'(grant), 32'b0100);
        req = '0;
        tick(); tick(); tick();
        reset = 1'b1;
        tick();
        check("rst mid tx",    32'(tx),    32'd1);
        check("rst mid grant", 32'(grant), 32'd0);
        check("rst mid busy",  32'(busy),  32'd0);
        check("rst mid owner", 32'(owner), 32'd0);
        tick(); tick();
        reset = 1'b0;
        tick();
        check("rst post tx",   32'(tx),   32'd1);
        check("rst post busy", 32'(busy), 32'd0);
        req = 4'b1111;
        tick();
        check("rst prio grant", 32'(grant), 32'b0001);
        check("rst prio owner", 32'(owner), 32'd0);
        req = '0;
        for (int c = 0; c < NB; c++) tick();
        check("rst final busy", 32'(busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
